spi_adc_sampler: RTL and testbench

//  Front end of the moving-average chain. Periodically reads a 10-bit serial ADC (MCP3001-style SPI,

---
 rtl/spi_adc_pkg.sv | 19 +
 rtl/spi_adc_period_timer.sv | 37 +++
 rtl/spi_adc_sampler.sv | 130 +++++++++++++
 tb/tb_spi_adc_sampler.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_adc_pkg.sv
// Shared definitions for the SPI ADC sampler.
//   state_t    : frame sequencer states
//   FRAME_BITS : SCLK periods per conversion frame
//   LEAD_BITS  : leading sample/null bits discarded at the start of a frame
//   ADC_W      : conversion result width
package spi_adc_pkg;

  localparam int unsigned FRAME_BITS = 13;
  localparam int unsigned LEAD_BITS  = 3;
  localparam int unsigned ADC_W      = 10;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETUP   = 2'd1,
    SHIFT   = 2'd2,
    RECOVER = 2'd3
  } state_t;

endpackage

// File: rtl/spi_adc_period_timer.sv
// Sample-rate timer. Emits a single-cycle tick every sample_period clk cycles.
// The first tick comes in the first cycle that enable=1 with a nonzero period.
//   clk, rst       : clock, asynchronous active-high reset
//   enable         : 0 holds the counter at zero, no ticks
//   sample_period  : cycles between ticks, 0 = no ticks; a new value takes effect at the next reload
//   tick           : combinational one-cycle pulse
module spi_adc_period_timer
  import spi_adc_pkg::*;
#(
  parameter int unsigned PERIOD_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic [PERIOD_W-1:0] sample_period,
  output logic                tick
);

  logic [PERIOD_W-1:0] cnt;
  logic                run;

  assign run  = enable && (sample_period != '0);
  assign tick = run && (cnt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (!run) begin
      cnt <= '0;
    end else if (cnt == '0) begin
      cnt <= sample_period - PERIOD_W'(1);
    end else begin
      cnt <= cnt - PERIOD_W'(1);
    end
  end

endmodule

// File: rtl/spi_adc_sampler.sv
// Periodic reader for an MCP3001-style 10-bit SPI ADC (mode 0, read-only).
// Each completed frame updates data_out and pulses strobe_out for one cycle.
//   clk, rst      : clock, asynchronous active-high reset
//   enable        : 1 = periodic sampling, 0 = no new frames (a running frame completes)
//   sample_period : clk cycles between frame starts, 0 = no sampling
//   adc_miso      : ADC serial data, sampled on the edge that raises adc_sclk
//   adc_sclk      : SPI clock, idle low
//   adc_cs_n      : ADC chip select, active low
//   data_out      : last completed conversion
//   strobe_out    : one-cycle pulse when data_out is updated
//   busy          : frame in progress (including CS-high recovery)
//   overrun       : one-cycle pulse when a period tick is dropped because busy
module spi_adc_sampler
  import spi_adc_pkg::*;
#(
  parameter int unsigned CLK_DIV     = 4,
  parameter int unsigned CS_HIGH_CYC = 4,
  parameter int unsigned PERIOD_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic [PERIOD_W-1:0] sample_period,
  input  logic                adc_miso,
  output logic                adc_sclk,
  output logic                adc_cs_n,
  output logic [ADC_W-1:0]    data_out,
  output logic                strobe_out,
  output logic                busy,
  output logic                overrun
);

  // One counter serves SETUP, the SCLK phase in SHIFT and RECOVER.
  localparam int unsigned CNT_MAX = (2 * CLK_DIV > CS_HIGH_CYC) ? 2 * CLK_DIV : CS_HIGH_CYC;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX);
  localparam int unsigned BIT_W   = $clog2(FRAME_BITS);

  state_t             state;
  logic [CNT_W-1:0]   div_cnt;
  logic [BIT_W-1:0]   bit_cnt;
  logic [ADC_W-1:0]   shift_reg;
  logic               tick;

  spi_adc_period_timer #(
    .PERIOD_W (PERIOD_W)
  ) u_timer (
    .clk           (clk),
    .rst           (rst),
    .enable        (enable),
    .sample_period (sample_period),
    .tick          (tick)
  );

  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      div_cnt    <= '0;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      data_out   <= '0;
      strobe_out <= 1'b0;
      overrun    <= 1'b0;
      adc_sclk   <= 1'b0;
      adc_cs_n   <= 1'b1;
    end else begin
      strobe_out <= 1'b0;
      overrun    <= tick && (state != IDLE);

      case (state)
        IDLE: begin
          if (tick) begin
            state    <= SETUP;
            adc_cs_n <= 1'b0;
            div_cnt  <= '0;
          end
        end

        SETUP: begin
          if (div_cnt == CNT_W'(CLK_DIV - 1)) begin
            // First SCLK rise. Bit 0 is a lead bit, so nothing is captured here.
            state    <= SHIFT;
            adc_sclk <= 1'b1;
            div_cnt  <= '0;
            bit_cnt  <= '0;
          end else begin
            div_cnt <= div_cnt + CNT_W'(1);
          end
        end

        SHIFT: begin
          if (div_cnt == CNT_W'(CLK_DIV - 1)) begin
            adc_sclk <= 1'b0;
            div_cnt  <= div_cnt + CNT_W'(1);
          end else if (div_cnt == CNT_W'(2 * CLK_DIV - 1)) begin
            div_cnt <= '0;
            if (bit_cnt == BIT_W'(FRAME_BITS - 1)) begin
              state      <= RECOVER;
              adc_cs_n   <= 1'b1;
              data_out   <= shift_reg;
              strobe_out <= 1'b1;
            end else begin
              // Rising edge for bit bit_cnt+1; only bits past the lead bits are kept.
              adc_sclk <= 1'b1;
              bit_cnt  <= bit_cnt + BIT_W'(1);
              if (bit_cnt >= BIT_W'(LEAD_BITS - 1)) begin
                shift_reg <= {shift_reg[ADC_W-2:0], adc_miso};
              end
            end
          end else begin
            div_cnt <= div_cnt + CNT_W'(1);
          end
        end

        RECOVER: begin
          if (div_cnt == CNT_W'(CS_HIGH_CYC - 1)) begin
            state   <= IDLE;
            div_cnt <= '0;
          end else begin
            div_cnt <= div_cnt + CNT_W'(1);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_adc_sampler.sv
// Self-checking bench for spi_adc_sampler with an ADC serial model and a
// cycle-indexed reference model derived from frame timing arithmetic.
module tb_spi_adc_sampler;

  localparam int CLK_DIV    = 4;
  localparam int CS_HIGH    = 4;
  localparam int PW         = 16;
  localparam int FRAME_LEN  = CLK_DIV * 27 + CS_HIGH;   // 112
  localparam int STROBE_OFS = CLK_DIV * 27;             // 108 edges after frame start

  logic          clk;
  logic          rst;
  logic          enable;
  logic [PW-1:0] sample_period;
  logic          adc_miso;
  logic          adc_sclk;
  logic          adc_cs_n;
  logic [9:0]    data_out;
  logic          strobe_out;
  logic          busy;
  logic          overrun;

  spi_adc_sampler #(
    .CLK_DIV     (CLK_DIV),
    .CS_HIGH_CYC (CS_HIGH),
    .PERIOD_W    (PW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .enable        (enable),
    .sample_period (sample_period),
    .adc_miso      (adc_miso),
    .adc_sclk      (adc_sclk),
    .adc_cs_n      (adc_cs_n),
    .data_out      (data_out),
    .strobe_out    (strobe_out),
    .busy          (busy),
    .overrun       (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int edge_n = 0;

  // Words served by the ADC model, one per frame, in order.
  logic [9:0] frame_words [0:1023];
  int         adc_idx = 0;
  int         ref_idx = 0;

  // ADC model state
  logic [9:0] adc_cur;
  int         adc_bit;
  bit         lead_ones = 1'b0;
  logic       prev_cs_n = 1'b1;
  logic       prev_sclk = 1'b0;
  int         rises = 0;
  bit         abandon = 1'b0;

  // Reference model state
  bit         armed;
  int         next_tick;
  int         last_start;
  logic [9:0] pend_word;
  logic [9:0] exp_data;

  // Observation bookkeeping
  int         strobe_cnt, ovr_cnt;
  int         first_strobe_edge, prev_strobe_edge, last_strobe_edge;
  bit         collect = 1'b0;
  logic [9:0] strobe_q [$];

  typedef struct {
    int period;
    bit en;
    int win;
    int exp_strobes;
    int exp_ovr;
    int exp_gap;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_n);
  endtask

  task automatic model_reset();
    armed      = 1'b0;
    next_tick  = 0;
    last_start = -100000;
    exp_data   = '0;
  endtask

  function automatic logic adc_bit_val(input int idx);
    if (idx < 3) return lead_ones ? 1'b1 : 1'($urandom_range(0, 1));
    return adc_cur[12 - idx];
  endfunction

  task automatic step();
    bit         en_s, rst_s, tick, strobe_e, ovr_e, busy_e, cs_e, sclk_e;
    logic [PW-1:0] per_s;
    int         k;
    @(posedge clk);
    en_s  = enable;
    per_s = sample_period;
    rst_s = rst;
    #1;
    edge_n++;
    k = edge_n;

    // ADC: new frame on CS fall, next bit after each SCLK fall
    if (prev_cs_n && !adc_cs_n) begin
      adc_cur  = frame_words[adc_idx % 1024];
      adc_idx++;
      adc_bit  = 0;
      rises    = 0;
      adc_miso = adc_bit_val(0);
    end else if (!adc_cs_n && prev_sclk && !adc_sclk) begin
      adc_bit++;
      adc_miso = adc_bit_val(adc_bit);
    end else if (adc_cs_n) begin
      adc_miso = 1'($urandom_range(0, 1));
    end
    if (!adc_cs_n && !prev_sclk && adc_sclk) rises++;
    if (!prev_cs_n && adc_cs_n && !abandon) chk("sclk_rises_per_frame", rises, 13);
    prev_cs_n = adc_cs_n;
    prev_sclk = adc_sclk;

    // Reference model
    strobe_e = 1'b0;
    ovr_e    = 1'b0;
    if (rst_s) begin
      model_reset();
    end else begin
      tick = 1'b0;
      if (!en_s || per_s == '0) begin
        armed = 1'b0;
      end else if (!armed || k == next_tick) begin
        tick      = 1'b1;
        armed     = 1'b1;
        next_tick = k + int'(per_s);
      end
      if (tick) begin
        if (k >= last_start + FRAME_LEN + 1) begin
          last_start = k;
          pend_word  = frame_words[ref_idx % 1024];
          ref_idx++;
        end else begin
          ovr_e = 1'b1;
        end
      end
      if (k == last_start + STROBE_OFS) begin
        strobe_e = 1'b1;
        exp_data = pend_word;
      end
    end
    busy_e = (k >= last_start) && (k <= last_start + FRAME_LEN - 1);
    cs_e   = !((k >= last_start) && (k <= last_start + STROBE_OFS - 1));
    sclk_e = (k >= last_start + CLK_DIV) && (k <= last_start + STROBE_OFS - 1) &&
             (((k - last_start - CLK_DIV) % (2 * CLK_DIV)) < CLK_DIV);

    chk("strobe_out", int'(strobe_out), int'(strobe_e));
    chk("overrun",    int'(overrun),    int'(ovr_e));
    chk("busy",       int'(busy),       int'(busy_e));
    chk("adc_cs_n",   int'(adc_cs_n),   int'(cs_e));
    chk("adc_sclk",   int'(adc_sclk),   int'(sclk_e));
    chk("data_out",   int'(data_out),   int'(exp_data));

    if (strobe_out) begin
      strobe_cnt++;
      if (first_strobe_edge < 0) first_strobe_edge = k;
      prev_strobe_edge = last_strobe_edge;
      last_strobe_edge = k;
      if (collect) strobe_q.push_back(data_out);
    end
    if (overrun) ovr_cnt++;
  endtask

  task automatic clear_obs();
    strobe_cnt        = 0;
    ovr_cnt           = 0;
    first_strobe_edge = -1;
    prev_strobe_edge  = -1;
    last_strobe_edge  = -1;
  endtask

  initial begin
    int start_edge;
    logic [9:0] seq [4];
    rst           = 1'b0;
    enable        = 1'b0;
    sample_period = '0;
    adc_miso      = 1'b0;
    for (int i = 0; i < 1024; i++) frame_words[i] = 10'($urandom);
    model_reset();
    clear_obs();

    vecs[0] = '{200, 1'b1, 1000, 5,   0, 200};
    vecs[1] = '{ 60, 1'b1,  600, 5,   5, 120};
    vecs[2] = '{  0, 1'b1, 1000, 0,   0,   0};
    vecs[3] = '{113, 1'b1,  500, 5,   0, 113};
    vecs[4] = '{112, 1'b1,  500, 3,   2, 224};
    vecs[5] = '{  1, 1'b1,  300, 3, 297, 113};
    vecs[6] = '{ 50, 1'b0,  400, 0,   0,   0};

    // Reset state
    #2 rst = 1'b1;
    #2;
    chk("rst_cs_n",    int'(adc_cs_n),   1);
    chk("rst_sclk",    int'(adc_sclk),   0);
    chk("rst_data",    int'(data_out),   0);
    chk("rst_strobe",  int'(strobe_out), 0);
    chk("rst_busy",    int'(busy),       0);
    chk("rst_overrun", int'(overrun),    0);
    repeat (3) step();
    rst = 1'b0;
    repeat (3) step();

    // Table-driven rate/overrun/latency vectors
    for (int i = 0; i < 7; i++) begin
      clear_obs();
      sample_period = PW'(vecs[i].period);
      enable        = vecs[i].en;
      start_edge    = edge_n + 1;
      repeat (vecs[i].win) step();
      enable = 1'b0;
      repeat (120) step();
      chk($sformatf("vec%0d_strobes", i), strobe_cnt, vecs[i].exp_strobes);
      chk($sformatf("vec%0d_overruns", i), ovr_cnt, vecs[i].exp_ovr);
      if (vecs[i].exp_strobes > 0)
        chk($sformatf("vec%0d_first_latency", i), first_strobe_edge - start_edge, STROBE_OFS);
      if (vecs[i].exp_gap != 0)
        chk($sformatf("vec%0d_strobe_gap", i), last_strobe_edge - prev_strobe_edge, vecs[i].exp_gap);
    end

    // Word sequence with lead bits driven high
    seq[0] = 10'h000; seq[1] = 10'h3FF; seq[2] = 10'h155; seq[3] = 10'h2AA;
    for (int i = 0; i < 4; i++) frame_words[(adc_idx + i) % 1024] = seq[i];
    lead_ones = 1'b1;
    strobe_q.delete();
    collect       = 1'b1;
    sample_period = PW'(200);
    enable        = 1'b1;
    repeat (800) step();
    enable = 1'b0;
    repeat (120) step();
    collect   = 1'b0;
    lead_ones = 1'b0;
    chk("seq_count", strobe_q.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < strobe_q.size()) chk($sformatf("seq_word%0d", i), int'(strobe_q[i]), int'(seq[i]));

    // Enable dropped mid-SHIFT, then re-enabled
    clear_obs();
    enable = 1'b1;
    repeat (30) step();
    enable = 1'b0;
    repeat (200) step();
    chk("drop_en_strobes", strobe_cnt, 1);
    chk("drop_en_cs_idle", int'(adc_cs_n), 1);
    enable = 1'b1;
    step();
    chk("reenable_first_cycle_cs", int'(adc_cs_n), 0);
    enable = 1'b0;
    repeat (120) step();

    // Reset during SHIFT bit 7
    frame_words[adc_idx % 1024]       = 10'h2A5;
    frame_words[(adc_idx + 1) % 1024] = 10'h1C3;
    enable = 1'b1;
    repeat (262) step();
    chk("pre_rst_data", int'(data_out), 'h2A5);
    abandon = 1'b1;
    rst     = 1'b1;
    #1;
    chk("mid_rst_cs_n", int'(adc_cs_n),   1);
    chk("mid_rst_sclk", int'(adc_sclk),   0);
    chk("mid_rst_data", int'(data_out),   0);
    chk("mid_rst_busy", int'(busy),       0);
    model_reset();
    clear_obs();
    repeat (5) step();
    chk("rst_no_strobe", strobe_cnt, 0);
    abandon = 1'b0;
    rst     = 1'b0;
    clear_obs();
    repeat (320) step();
    chk("post_rst_strobes", strobe_cnt, 2);
    enable = 1'b0;
    repeat (120) step();

    // Randomized segments
    for (int s = 0; s < 8; s++) begin
      sample_period = ($urandom_range(0, 5) == 0) ? '0 : PW'($urandom_range(1, 260));
      enable        = ($urandom_range(0, 3) != 0);
      repeat ($urandom_range(100, 500)) step();
    end
    enable = 1'b0;
    repeat (120) step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
